sensor_config_sequencer: RTL and testbench

- Walks a register-configuration table (synchronous ROM/BRAM) and drives the sensor serial controller's parallel register interface.
- Issues register writes, read-back verifies and timed delays to either the analog or the digital chip-enable target.
- When no sequence is running, also serves single register accesses from a host port, so that one block owns the serial controller.

---
 rtl/sensor_cfg_pkg.sv | 35 +++
 rtl/cfg_delay_timer.sv | 41 ++++
 rtl/sensor_config_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sensor_config_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_cfg_pkg.sv
// Shared definitions for the sensor configuration sequencer: table entry layout,
// opcodes and FSM state encoding.
package sensor_cfg_pkg;

  localparam int unsigned ENTRY_W = 18;
  localparam int unsigned TICK_W  = 15;

  // Entry layout: {op[17:16], chip[15], addr[14:8], data[7:0]}
  localparam int unsigned OP_HI    = 17;
  localparam int unsigned OP_LO    = 16;
  localparam int unsigned CHIP_BIT = 15;
  localparam int unsigned ADDR_HI  = 14;
  localparam int unsigned ADDR_LO  = 8;
  localparam int unsigned DATA_HI  = 7;
  localparam int unsigned DATA_LO  = 0;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b01;
  localparam logic [1:0] OP_DELAY  = 2'b10;
  localparam logic [1:0] OP_END    = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitBusy,
    StWaitIdle,
    StDelay,
    StHostIssue,
    StHostWaitBusy,
    StHostWaitIdle
  } state_e;

endpackage

// File: rtl/cfg_delay_timer.sv
// Delay timer: waits ticks_i * PRESCALE cycles after a load; done_o is high whenever
// the tick count has reached zero.
module cfg_delay_timer
  import sensor_cfg_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [TICK_W-1:0] ticks_i,
  output logic              done_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  logic [PW-1:0]     pre_q;
  logic [TICK_W-1:0] tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= '0;
    end else if (load_i) begin
      pre_q  <= PreMax;
      tick_q <= ticks_i;
    end else if (tick_q != '0) begin
      // One tick elapses when the prescaler wraps.
      if (pre_q == '0) begin
        pre_q  <= PreMax;
        tick_q <= tick_q - 1'b1;
      end else begin
        pre_q <= pre_q - 1'b1;
      end
    end
  end

  assign done_o = (tick_q == '0);

endmodule

// File: rtl/sensor_config_sequencer.sv
// Walks a register-configuration table into the sensor serial controller and serves
// single host register accesses while no sequence is running.
module sensor_config_sequencer
  import sensor_cfg_pkg::*;
#(
  parameter int unsigned TBL_AW         = 6,
  parameter int unsigned DELAY_PRESCALE = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               running_o,
  output logic               done_o,
  output logic               error_o,
  output logic [TBL_AW-1:0]  error_index_o,
  output logic [TBL_AW-1:0]  tbl_addr_o,
  input  logic [ENTRY_W-1:0] tbl_data_i,
  output logic [6:0]         ser_address_o,
  output logic [7:0]         ser_write_data_o,
  output logic               ser_write_valid_o,
  output logic               ser_read_start_o,
  input  logic [7:0]         ser_read_data_i,
  input  logic               ser_busy_i,
  output logic               ser_mux_ce_a_nd_o,
  input  logic               host_req_i,
  input  logic               host_rd_nwr_i,
  input  logic               host_chip_i,
  input  logic [6:0]         host_addr_i,
  input  logic [7:0]         host_wdata_i,
  output logic               host_ack_o,
  output logic [7:0]         host_rdata_o
);

  localparam logic [TBL_AW-1:0] LastIndex = '1;

  state_e            state_q;
  logic [TBL_AW-1:0] index_q;
  logic [1:0]        op_q;
  logic [7:0]        data_q;
  logic              host_rd_q;

  logic timer_load;
  logic timer_done;
  logic verify_fail;
  logic entry_complete;

  assign timer_load = (state_q == StDecode) && (tbl_data_i[OP_HI:OP_LO] == OP_DELAY);

  assign verify_fail = (state_q == StWaitIdle) && !ser_busy_i && (op_q == OP_VERIFY) &&
                       (ser_read_data_i != data_q);

  assign entry_complete = ((state_q == StWaitIdle) && !ser_busy_i && !verify_fail) ||
                          ((state_q == StDelay) && timer_done);

  cfg_delay_timer #(
    .PRESCALE(DELAY_PRESCALE)
  ) u_delay_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .ticks_i(tbl_data_i[TICK_W-1:0]),
    .done_o (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      index_q           <= '0;
      op_q              <= OP_WRITE;
      data_q            <= '0;
      host_rd_q         <= 1'b0;
      running_o         <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
      error_index_o     <= '0;
      tbl_addr_o        <= '0;
      ser_address_o     <= '0;
      ser_write_data_o  <= '0;
      ser_write_valid_o <= 1'b0;
      ser_read_start_o  <= 1'b0;
      ser_mux_ce_a_nd_o <= 1'b0;
      host_ack_o        <= 1'b0;
      host_rdata_o      <= '0;
    end else begin
      ser_write_valid_o <= 1'b0;
      ser_read_start_o  <= 1'b0;
      host_ack_o        <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            error_index_o <= '0;
            index_q       <= '0;
            tbl_addr_o    <= '0;
            running_o     <= 1'b1;
            state_q       <= StFetch;
          end else if (host_req_i && !host_ack_o) begin
            // The ack cycle is skipped so a still-held request is not served twice.
            ser_mux_ce_a_nd_o <= host_chip_i;
            ser_address_o     <= host_addr_i;
            ser_write_data_o  <= host_wdata_i;
            host_rd_q         <= host_rd_nwr_i;
            state_q           <= StHostIssue;
          end
        end

        StFetch: state_q <= StDecode;

        StDecode: begin
          op_q              <= tbl_data_i[OP_HI:OP_LO];
          data_q            <= tbl_data_i[DATA_HI:DATA_LO];
          ser_mux_ce_a_nd_o <= tbl_data_i[CHIP_BIT];
          ser_address_o     <= tbl_data_i[ADDR_HI:ADDR_LO];
          ser_write_data_o  <= tbl_data_i[DATA_HI:DATA_LO];
          case (tbl_data_i[OP_HI:OP_LO])
            OP_WRITE, OP_VERIFY: state_q <= StIssue;
            OP_DELAY:            state_q <= StDelay;
            default: begin
              done_o    <= 1'b1;
              running_o <= 1'b0;
              state_q   <= StIdle;
            end
          endcase
        end

        StIssue: begin
          if (!ser_busy_i) begin
            if (op_q == OP_VERIFY) ser_read_start_o <= 1'b1;
            else                   ser_write_valid_o <= 1'b1;
            state_q <= StWaitBusy;
          end
        end

        StWaitBusy: if (ser_busy_i) state_q <= StWaitIdle;

        StWaitIdle, StDelay: begin
          if (verify_fail) begin
            error_o       <= 1'b1;
            error_index_o <= index_q;
            running_o     <= 1'b0;
            state_q       <= StIdle;
          end else if (entry_complete) begin
            if (index_q == LastIndex) begin
              done_o    <= 1'b1;
              running_o <= 1'b0;
              state_q   <= StIdle;
            end else begin
              index_q    <= index_q + 1'b1;
              tbl_addr_o <= index_q + 1'b1;
              state_q    <= StFetch;
            end
          end
        end

        StHostIssue: begin
          if (!ser_busy_i) begin
            if (host_rd_q) ser_read_start_o <= 1'b1;
            else           ser_write_valid_o <= 1'b1;
            state_q <= StHostWaitBusy;
          end
        end

        StHostWaitBusy: if (ser_busy_i) state_q <= StHostWaitIdle;

        StHostWaitIdle: begin
          if (!ser_busy_i) begin
            host_ack_o <= 1'b1;
            if (host_rd_q) host_rdata_o <= ser_read_data_i;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_config_sequencer.sv
// Scoreboard bench: expected serial transactions are queued with the stimulus and
// compared as the sequencer strobes them into a behavioural serial controller.
module tb_sensor_config_sequencer;
  import sensor_cfg_pkg::*;

  localparam int unsigned AW  = 3;
  localparam int unsigned PRE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              running_o, done_o, error_o;
  logic [AW-1:0]     error_index_o, tbl_addr_o;
  logic [ENTRY_W-1:0] tbl_data_i = '0;
  logic [6:0]        ser_address_o;
  logic [7:0]        ser_write_data_o;
  logic              ser_write_valid_o, ser_read_start_o;
  logic [7:0]        ser_read_data_i = '0;
  logic              ser_busy_i = 1'b0;
  logic              ser_mux_ce_a_nd_o;
  logic              host_req_i = 1'b0, host_rd_nwr_i = 1'b0, host_chip_i = 1'b0;
  logic [6:0]        host_addr_i = '0;
  logic [7:0]        host_wdata_i = '0;
  logic              host_ack_o;
  logic [7:0]        host_rdata_o;

  logic [ENTRY_W-1:0] tbl [2**AW];
  logic [16:0]        sb [$];
  logic [7:0]         resp_q [$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 cyc = 0;
  int                 glitch = 0;
  logic [AW-1:0]      max_addr = '0;
  logic               cur_chip = 1'b0;
  logic [6:0]         cur_addr = '0;
  logic [1:0]         busy_cnt = '0;
  logic [7:0]         pend_rd = '0;
  logic [35:0]        outs;

  assign outs = {running_o, done_o, error_o, error_index_o, tbl_addr_o, ser_address_o,
                 ser_write_data_o, ser_write_valid_o, ser_read_start_o, ser_mux_ce_a_nd_o,
                 host_ack_o, host_rdata_o};

  sensor_config_sequencer #(
    .TBL_AW        (AW),
    .DELAY_PRESCALE(PRE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .running_o        (running_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .error_index_o    (error_index_o),
    .tbl_addr_o       (tbl_addr_o),
    .tbl_data_i       (tbl_data_i),
    .ser_address_o    (ser_address_o),
    .ser_write_data_o (ser_write_data_o),
    .ser_write_valid_o(ser_write_valid_o),
    .ser_read_start_o (ser_read_start_o),
    .ser_read_data_i  (ser_read_data_i),
    .ser_busy_i       (ser_busy_i),
    .ser_mux_ce_a_nd_o(ser_mux_ce_a_nd_o),
    .host_req_i       (host_req_i),
    .host_rd_nwr_i    (host_rd_nwr_i),
    .host_chip_i      (host_chip_i),
    .host_addr_i      (host_addr_i),
    .host_wdata_i     (host_wdata_i),
    .host_ack_o       (host_ack_o),
    .host_rdata_o     (host_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input logic [1:0] op, input logic chip,
                                             input logic [6:0] a, input logic [7:0] d);
    return {op, chip, a, d};
  endfunction

  function automatic logic [16:0] exp_w(input logic chip, input logic [6:0] a,
                                        input logic [7:0] d);
    return {1'b0, chip, a, d};
  endfunction

  function automatic logic [16:0] exp_r(input logic chip, input logic [6:0] a);
    return {1'b1, chip, a, 8'h00};
  endfunction

  // Synchronous table ROM and cycle counter.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    tbl_data_i <= tbl[tbl_addr_o];
  end

  // Serial controller: busy rises the cycle after a strobe, lasts three cycles.
  always @(posedge clk) begin
    if (rst) begin
      ser_busy_i      <= 1'b0;
      busy_cnt        <= '0;
      ser_read_data_i <= '0;
    end else if (ser_write_valid_o || ser_read_start_o) begin
      ser_busy_i <= 1'b1;
      busy_cnt   <= 2'd3;
      if (ser_read_start_o) begin
        if (resp_q.size() > 0) pend_rd <= resp_q.pop_front();
        else                   pend_rd <= 8'hEE;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1'b1;
      if (busy_cnt == 2'd1) begin
        ser_busy_i      <= 1'b0;
        ser_read_data_i <= pend_rd;
      end
    end
  end

  // Scoreboard and mux/address stability monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (running_o && tbl_addr_o > max_addr) max_addr = tbl_addr_o;
      if (ser_busy_i && (ser_mux_ce_a_nd_o !== cur_chip || ser_address_o !== cur_addr))
        glitch++;
      if (ser_write_valid_o || ser_read_start_o) begin
        logic [16:0] obs;
        check("strobe_while_busy", ser_busy_i, 0);
        check("dual_strobe", ser_write_valid_o & ser_read_start_o, 0);
        obs = {ser_read_start_o, ser_mux_ce_a_nd_o, ser_address_o,
               ser_read_start_o ? 8'h00 : ser_write_data_o};
        if (sb.size() == 0) check("unexpected_txn", sb.size(), 1);
        else                check("txn", obs, sb.pop_front());
        cur_chip = ser_mux_ce_a_nd_o;
        cur_addr = ser_address_o;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (running_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_run_ends"}, running_o, 0);
  endtask

  task automatic delay_gap(output int gap);
    int n = 0;
    int t0;
    pulse_start();
    while (!(running_o && tbl_addr_o == 3'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n  = 0;
    while (!(ser_write_valid_o && ser_address_o == 7'h02) && n < 500) begin
      @(negedge clk);
      n++;
    end
    gap = cyc - t0;
    wait_run("delay");
  endtask

  task automatic fill_end();
    for (int i = 0; i < 2**AW; i++) tbl[i] = ent(OP_END, 1'b0, 7'h00, 8'h00);
  endtask

  initial begin
    int gap;
    int n;
    fill_end();
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 0);
    rst = 1'b0;

    // Two writes to alternating chips, then END.
    tbl[0] = ent(OP_WRITE, 1'b1, 7'h10, 8'hA5);
    tbl[1] = ent(OP_WRITE, 1'b0, 7'h22, 8'h3C);
    sb.push_back(exp_w(1'b1, 7'h10, 8'hA5));
    sb.push_back(exp_w(1'b0, 7'h22, 8'h3C));
    pulse_start();
    check("t1_running", running_o, 1);
    wait_run("t1");
    check("t1_done", done_o, 1);
    check("t1_error", error_o, 0);
    check("t1_sb_empty", sb.size(), 0);

    // Verify pass at index 1, mismatch at index 3 stops the run.
    fill_end();
    tbl[0] = ent(OP_WRITE,  1'b0, 7'h01, 8'h11);
    tbl[1] = ent(OP_VERIFY, 1'b1, 7'h05, 8'h7F);
    tbl[2] = ent(OP_WRITE,  1'b0, 7'h02, 8'h22);
    tbl[3] = ent(OP_VERIFY, 1'b1, 7'h05, 8'h7F);
    tbl[4] = ent(OP_WRITE,  1'b0, 7'h03, 8'h33);
    sb.push_back(exp_w(1'b0, 7'h01, 8'h11));
    sb.push_back(exp_r(1'b1, 7'h05));
    sb.push_back(exp_w(1'b0, 7'h02, 8'h22));
    sb.push_back(exp_r(1'b1, 7'h05));
    resp_q.push_back(8'h7F);
    resp_q.push_back(8'h7E);
    max_addr = '0;
    pulse_start();
    check("t2_done_cleared", done_o, 0);
    wait_run("t2");
    check("t2_error", error_o, 1);
    check("t2_error_index", error_index_o, 3);
    check("t2_done", done_o, 0);
    check("t2_max_fetch", max_addr, 3);
    check("t2_sb_empty", sb.size(), 0);

    // Delay of 3 ticks (12 cycles) versus zero ticks.
    fill_end();
    tbl[0] = ent(OP_WRITE, 1'b0, 7'h01, 8'h01);
    tbl[1] = ent(OP_DELAY, 1'b0, 7'h00, 8'h03);
    tbl[2] = ent(OP_WRITE, 1'b0, 7'h02, 8'h02);
    sb.push_back(exp_w(1'b0, 7'h01, 8'h01));
    sb.push_back(exp_w(1'b0, 7'h02, 8'h02));
    delay_gap(gap);
    check("t3_gap_n3", gap, 18);
    check("t3_error_cleared", error_o, 0);
    check("t3_error_index_cleared", error_index_o, 0);
    check("t3_done", done_o, 1);
    tbl[1] = ent(OP_DELAY, 1'b0, 7'h00, 8'h00);
    sb.push_back(exp_w(1'b0, 7'h01, 8'h01));
    sb.push_back(exp_w(1'b0, 7'h02, 8'h02));
    delay_gap(gap);
    check("t3_gap_n0", gap, 6);
    check("t3_sb_empty", sb.size(), 0);

    // Host read while idle.
    sb.push_back(exp_r(1'b1, 7'h30));
    resp_q.push_back(8'h5A);
    @(negedge clk);
    host_req_i = 1'b1; host_rd_nwr_i = 1'b1; host_chip_i = 1'b1;
    host_addr_i = 7'h30; host_wdata_i = 8'h00;
    n = 0;
    while (!host_ack_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_ack", host_ack_o, 1);
    check("t4_rdata", host_rdata_o, 8'h5A);
    host_req_i = 1'b0;
    @(negedge clk);
    check("t4_ack_pulse", host_ack_o, 0);
    check("t4_rdata_hold", host_rdata_o, 8'h5A);

    // Host write requested mid-run is served only after the run ends.
    fill_end();
    for (int i = 0; i < 3; i++) begin
      tbl[i] = ent(OP_WRITE, 1'b1, 7'h50 + 7'(i), 8'hC0 + 8'(i));
      sb.push_back(exp_w(1'b1, 7'h50 + 7'(i), 8'hC0 + 8'(i)));
    end
    sb.push_back(exp_w(1'b0, 7'h44, 8'h99));
    pulse_start();
    host_req_i = 1'b1; host_rd_nwr_i = 1'b0; host_chip_i = 1'b0;
    host_addr_i = 7'h44; host_wdata_i = 8'h99;
    n = 0;
    while (!host_ack_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t4m_ack", host_ack_o, 1);
    check("t4m_done_before_ack", done_o, 1);
    check("t4m_rdata_unchanged", host_rdata_o, 8'h5A);
    host_req_i = 1'b0;
    check("t4m_sb_empty", sb.size(), 0);

    // No END: all entries written, no wrap; a second start mid-run is ignored.
    for (int i = 0; i < 2**AW; i++) begin
      tbl[i] = ent(OP_WRITE, 1'(i), 7'h40 + 7'(i), 8'(i * 3));
      sb.push_back(exp_w(1'(i), 7'h40 + 7'(i), 8'(i * 3)));
    end
    pulse_start();
    repeat (8) @(negedge clk);
    pulse_start();
    wait_run("t5");
    check("t5_done", done_o, 1);
    check("t5_sb_empty", sb.size(), 0);
    repeat (20) @(negedge clk);
    check("t5_still_idle", running_o, 0);

    // Reset during WAIT_IDLE, then a clean rerun from index 0.
    fill_end();
    tbl[0] = ent(OP_WRITE, 1'b1, 7'h11, 8'h77);
    tbl[1] = ent(OP_WRITE, 1'b0, 7'h12, 8'h88);
    sb.push_back(exp_w(1'b1, 7'h11, 8'h77));
    sb.push_back(exp_w(1'b0, 7'h12, 8'h88));
    pulse_start();
    n = 0;
    while (!ser_busy_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t6_busy_before_rst", ser_busy_i, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", outs, 0);
    rst = 1'b0;
    sb.delete();
    resp_q.delete();
    sb.push_back(exp_w(1'b1, 7'h11, 8'h77));
    sb.push_back(exp_w(1'b0, 7'h12, 8'h88));
    pulse_start();
    wait_run("t6");
    check("t6_done", done_o, 1);
    check("t6_error", error_o, 0);
    check("t6_sb_empty", sb.size(), 0);

    check("mux_addr_stable", glitch, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
